// File: rtl/mmcm_drp_pkg.sv
// Shared types and frequency profiles for the MMCM DRP sequencer.
// Entries are applied in table order as read-modify-write pairs.
package mmcm_drp_pkg;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  localparam int N_ENTRIES = 4;

  // ClkReg1 keeps only its reserved bit 12; ClkReg2 keeps bits 15:10 and forces even-divide, no-delay.
  localparam drp_entry_t PROFILES [2][N_ENTRIES] = '{
    '{ '{7'h08, 16'h1000, 16'h0041}, '{7'h09, 16'hFC00, 16'h0000},
       '{7'h14, 16'h1000, 16'h0041}, '{7'h15, 16'hFC00, 16'h0000} },
    '{ '{7'h08, 16'h1000, 16'h0082}, '{7'h09, 16'hFC00, 16'h0000},
       '{7'h14, 16'h1000, 16'h0041}, '{7'h15, 16'hFC00, 16'h0000} }
  };

  typedef enum logic [3:0] {
    PWRUP_RST, LOCK_WAIT, IDLE, RST_HOLD, RD_REQ,
    RD_WAIT, WR_REQ, WR_WAIT, RELEASE, ERR
  } state_t;

endpackage

// File: rtl/mmcm_drp_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous MMCM LOCKED signal; 2-cycle latency.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mmcm_drp_sequencer.sv
// MMCM power-up reset/lock sequencing and DRP reprogramming from stored profiles.
// One DRP access outstanding at a time; start is ignored unless IDLE.
module mmcm_drp_sequencer
  import mmcm_drp_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 64,
  parameter int DRDY_TIMEOUT    = 255,
  parameter int LOCK_TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        profile_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        locked_out,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);
  localparam int          IDX_W     = $clog2(N_ENTRIES);
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] DRDY_LIM  = 32'(DRDY_TIMEOUT);
  localparam logic [31:0] LOCK_LIM  = 32'(LOCK_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

  state_t             state, state_nxt;
  logic [31:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               sel, sel_nxt;
  logic [15:0]        wr_reg, wr_reg_nxt;
  logic               error_q, error_nxt;
  logic               rst_q, rst_nxt;
  logic               pwrup, pwrup_nxt;
  logic               lock_sync;
  drp_entry_t         entry;

  sync2 u_lock_sync (.clk(clk), .rst_n(rst_n), .d(mmcm_locked), .q(lock_sync));

  assign entry      = PROFILES[sel][idx];
  assign busy       = (state != IDLE);
  assign error      = error_q;
  assign mmcm_rst   = rst_q;
  assign locked_out = lock_sync & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PWRUP_RST;
      cnt     <= '0;
      idx     <= '0;
      sel     <= 1'b0;
      wr_reg  <= '0;
      error_q <= 1'b0;
      rst_q   <= 1'b1;
      pwrup   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      sel     <= sel_nxt;
      wr_reg  <= wr_reg_nxt;
      error_q <= error_nxt;
      rst_q   <= rst_nxt;
      pwrup   <= pwrup_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    sel_nxt    = sel;
    wr_reg_nxt = wr_reg;
    error_nxt  = error_q;
    rst_nxt    = rst_q;
    pwrup_nxt  = pwrup;
    done       = 1'b0;
    drp_den    = 1'b0;
    drp_dwe    = 1'b0;
    drp_daddr  = '0;
    drp_di     = '0;
    case (state)
      PWRUP_RST: if (cnt == HOLD_LAST) state_nxt = RELEASE;
      IDLE: begin
        if (start) begin
          sel_nxt   = profile_sel;
          error_nxt = 1'b0;
          rst_nxt   = 1'b1;
          state_nxt = RST_HOLD;
        end
      end
      RST_HOLD: begin
        rst_nxt = 1'b1;
        idx_nxt = '0;
        if (cnt == HOLD_LAST) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        drp_den   = 1'b1;
        drp_daddr = entry.addr;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        // drdy takes priority over a timeout landing in the same cycle
        if (drp_drdy) begin
          wr_reg_nxt = (drp_do & entry.mask) | entry.data;
          state_nxt  = WR_REQ;
        end else if (cnt == DRDY_LIM) begin
          state_nxt = ERR;
        end
      end
      WR_REQ: begin
        drp_den   = 1'b1;
        drp_dwe   = 1'b1;
        drp_daddr = entry.addr;
        drp_di    = wr_reg;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp_drdy) begin
          if (idx == IDX_LAST) begin
            state_nxt = RELEASE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = RD_REQ;
          end
        end else if (cnt == DRDY_LIM) begin
          state_nxt = ERR;
        end
      end
      RELEASE: begin
        rst_nxt   = 1'b0;
        state_nxt = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        // the power-up lock is silent; only requested sequences report done
        if (lock_sync) begin
          done      = ~pwrup;
          pwrup_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (cnt == LOCK_LIM) begin
          pwrup_nxt = 1'b0;
          state_nxt = ERR;
        end
      end
      ERR: begin
        error_nxt = 1'b1;
        rst_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = PWRUP_RST;
    endcase
    cnt_nxt = (state_nxt != state) ? '0 : cnt + 32'd1;
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Randomized bench for mmcm_drp_sequencer: DRP/MMCM behavioural models, expected
// DRP accesses and done pulses queued at stimulus time and checked by a monitor.
module tb_mmcm_drp_sequencer;
  localparam int RST_HOLD = 64;
  localparam int DRDY_TO  = 255;
  localparam int LOCK_TO  = 1000;
  localparam int LOCK_DLY = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, profile_sel;
  logic        busy, done, error, locked_out, mmcm_rst;
  logic        mmcm_locked;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;

  mmcm_drp_sequencer #(.RST_HOLD_CYCLES(RST_HOLD), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .profile_sel(profile_sel),
    .busy(busy), .done(done), .error(error), .locked_out(locked_out),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [6:0] addr; logic [15:0] dat; } acc_t;
  acc_t exp_q[$];
  int   exp_done = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [15:0] mem [128];
  int   lat = 3;
  int   drop_read = 0;
  int   rd_count = 0;
  bit   withhold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference profile from the MMCM register encoding: ClkReg1 = {high,low} counts, ClkReg2 even divide.
  task automatic ref_entry(input int p, input int i, output logic [6:0] a,
                           output logic [15:0] m, output logic [15:0] d);
    int addrs [4] = '{8, 9, 20, 21};
    int div;
    a = 7'(addrs[i]);
    if (i % 2 == 0) begin
      div = (i < 2) ? ((p != 0) ? 4 : 2) : 2;
      m = 16'h1000;
      d = 16'(((div / 2) << 6) | (div - div / 2));
    end else begin
      m = 16'hFC00;
      d = 16'h0000;
    end
  endtask

  task automatic expect_run(input int p, input int n_acc);
    logic [6:0] a; logic [15:0] m, d;
    for (int i = 0; i < 4; i++) begin
      ref_entry(p, i, a, m, d);
      if (2 * i < n_acc)     exp_q.push_back('{1'b0, a, 16'h0});
      if (2 * i + 1 < n_acc) exp_q.push_back('{1'b1, a, (mem[a] & m) | d});
    end
  endtask

  // DRP slave: fixed latency, optional swallowed read
  int          remaining = 0;
  bit          pending = 1'b0, pwr = 1'b0, pdrop = 1'b0;
  logic [6:0]  paddr;
  logic [15:0] pdi;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending  = 1'b0;
      drp_drdy = 1'b0;
    end else begin
      drp_drdy = 1'b0;
      if (pending) begin
        remaining--;
        if (remaining <= 0) begin
          pending = 1'b0;
          if (!pdrop) begin
            drp_drdy = 1'b1;
            if (pwr) mem[paddr] = pdi;
            else     drp_do = mem[paddr];
          end
        end
      end
      if (drp_den) begin
        check("one_outstanding", 32'(pending), 32'd0);
        pending = 1'b1; remaining = lat; paddr = drp_daddr; pwr = drp_dwe; pdi = drp_di;
        pdrop = 1'b0;
        if (!drp_dwe) begin
          rd_count++;
          pdrop = (rd_count == drop_read);
        end
      end
    end
  end

  int lock_cnt = 0;
  always @(negedge clk) begin
    if (mmcm_rst) begin
      lock_cnt    = 0;
      mmcm_locked = 1'b0;
    end else if (!withhold) begin
      lock_cnt++;
      if (lock_cnt >= LOCK_DLY) mmcm_locked = 1'b1;
    end
  end

  bit prev_den = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (drp_den) begin
        acc_t e;
        check("den_single_cycle", 32'(prev_den), 32'd0);
        check("drp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("drp_we", 32'(drp_dwe), 32'(e.wr));
          check("drp_addr", 32'(drp_daddr), 32'(e.addr));
          if (e.wr) check("drp_wdata", 32'(drp_di), 32'(e.dat));
        end
      end
      if (done) begin
        check("done_expected", 32'(exp_done > 0), 32'd1);
        if (exp_done > 0) exp_done--;
      end
      prev_den = drp_den;
    end else begin
      prev_den = 1'b0;
    end
  end

  task automatic issue_start(input bit p);
    start = 1'b1; profile_sel = p;
    @(negedge clk);
    start = 1'b0; profile_sel = 1'($urandom);
    check("start_busy", 32'(busy), 32'd1);
    check("start_locked_drop", 32'(locked_out), 32'd0);
    check("start_error_clear", 32'(error), 32'd0);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    ok = !busy;
  endtask

  task automatic power_up_check();
    int n = 0; bit ok;
    while (mmcm_rst && n < 500) begin @(negedge clk); n++; end
    check("pwrup_rst_hold", 32'(n >= RST_HOLD && n <= RST_HOLD + 1), 32'd1);
    n = 0;
    while (!(locked_out && !busy) && n < 500) begin @(negedge clk); n++; end
    check("pwrup_lock_time", 32'(n >= LOCK_DLY && n <= LOCK_DLY + 6), 32'd1);
    wait_idle(10, ok);
    check("pwrup_idle", 32'(ok), 32'd1);
    check("pwrup_no_error", 32'(error), 32'd0);
  endtask

  task automatic finish_run(input string tag);
    bit ok;
    wait_idle(4000, ok);
    check({tag, "_completes"}, 32'(ok), 32'd1);
    check({tag, "_all_accesses"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_one_done"}, 32'(exp_done), 32'd0);
    check({tag, "_no_error"}, 32'(error), 32'd0);
    check({tag, "_locked"}, 32'(locked_out), 32'd1);
    check({tag, "_rst_low"}, 32'(mmcm_rst), 32'd0);
  endtask

  task automatic run_normal(input bit p, input string tag);
    rd_count = 0;
    expect_run(int'(p), 8);
    exp_done++;
    issue_start(p);
    finish_run(tag);
  endtask

  task automatic randomize_mem();
    int addrs [4] = '{8, 9, 20, 21};
    foreach (addrs[i]) mem[addrs[i]] = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok; int n, seen; bit p;
    foreach (mem[i]) mem[i] = 16'($urandom);
    rst_n = 1'b0; start = 1'b0; profile_sel = 1'b0;
    drp_drdy = 1'b0; drp_do = 16'h0; mmcm_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_locked_out", 32'(locked_out), 32'd0);
    check("rst_drp", 32'({drp_den, drp_dwe, drp_daddr, drp_di}), 32'd0);
    rst_n = 1'b1;
    power_up_check();

    // profile 1 with all-ones readback at ClkReg1
    randomize_mem();
    mem[8] = 16'hFFFF; lat = 3;
    run_normal(1'b1, "prof1");
    check("prof1_wr_0x08", 32'(mem[8]), 32'h1082);

    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      lat = int'($urandom_range(1, 6));
      run_normal(1'($urandom), "rand");
    end

    // start pulsed during WR_WAIT must be ignored
    randomize_mem(); lat = 3; rd_count = 0;
    p = 1'($urandom);
    expect_run(int'(p), 8); exp_done++;
    issue_start(p);
    n = 0;
    while (!drp_dwe && n < 500) begin @(negedge clk); n++; end
    check("ign_saw_write", 32'(drp_dwe), 32'd1);
    @(negedge clk);
    start = 1'b1; profile_sel = ~p;
    @(negedge clk);
    start = 1'b0;
    finish_run("ignored_start");

    // second read never acknowledged
    randomize_mem(); lat = int'($urandom_range(1, 5)); rd_count = 0; drop_read = 2;
    expect_run(0, 3);
    issue_start(1'b0);
    seen = 0; n = 0;
    while (seen < 2 && n < 1000) begin
      @(negedge clk); n++;
      if (drp_den && !drp_dwe) seen++;
    end
    check("drop_second_read", 32'(seen), 32'd2);
    n = 0;
    while (!error && n < 1000) begin @(negedge clk); n++; end
    check("drdy_timeout_len", 32'(n >= DRDY_TO + 1 && n <= DRDY_TO + 4), 32'd1);
    check("drdy_to_error", 32'(error), 32'd1);
    check("drdy_to_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("drdy_to_idle", 32'(busy), 32'd0);
    check("drdy_to_queue", 32'(exp_q.size()), 32'd0);
    drop_read = 0;
    run_normal(1'($urandom), "after_drdy_err");

    // lock withheld
    randomize_mem(); lat = 2; rd_count = 0; withhold = 1'b1;
    expect_run(1, 8);
    issue_start(1'b1);
    wait_idle(4000, ok);
    check("lockto_completes", 32'(ok), 32'd1);
    check("lockto_error", 32'(error), 32'd1);
    check("lockto_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("lockto_accesses", 32'(exp_q.size()), 32'd0);
    withhold = 1'b0;
    run_normal(1'b0, "after_lock_err");

    // rst_n during RD_WAIT
    lat = 4; rd_count = 0;
    expect_run(0, 1);
    issue_start(1'b0);
    n = 0;
    while (!drp_den && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_den", 32'(drp_den), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    power_up_check();
    check("abort_no_done", 32'(exp_done), 32'd0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_sequencer.md
# mmcm_drp_sequencer

Controls the board's single MMCME3 clock generator, which multiplies the 300 MHz differential oscillator and drives `clk_out`. The block handles the MMCM reset and lock sequence at power-up. On request, it also reprograms the MMCM through its DRP port, using one of two stored frequency profiles. Each register is updated by read-modify-write, with the MMCM held in reset during the writes, and the block then waits for re-lock. It runs on the buffered oscillator clock, never on an MMCM output.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, default 64: cycles `mmcm_rst` is held high before release.
- `DRDY_TIMEOUT`, default 255: maximum cycles to wait for `drp_drdy` after a DRP access.
- `LOCK_TIMEOUT`, default 65535: maximum cycles to wait for lock after reset release.

Ports:
- `clk` in 1: buffered 300 MHz oscillator (`osc_300`).
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle reconfiguration request.
- `profile_sel` in 1: profile to load; sampled only on an accepted `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: single-cycle pulse when a sequence completes and lock is achieved.
- `error` out 1: sticky; set on a DRDY or lock timeout; cleared on the next accepted `start`.
- `locked_out` out 1: synchronized MMCM lock status, forced to 0 while `busy`.
- `mmcm_rst` out 1: drives MMCM `RST`.
- `mmcm_locked` in 1: raw MMCM `LOCKED` (asynchronous).
- `drp_den` out 1, `drp_dwe` out 1: DRP enable and write-enable strobes.
- `drp_daddr` out 7: DRP address.
- `drp_di` out 16: DRP write data.
- `drp_do` in 16: DRP read data.
- `drp_drdy` in 1: DRP access complete.

## Operation
- States: PWRUP_RST, LOCK_WAIT, IDLE, RST_HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, ERR.
- Output reset values (`rst_n` low):
  - `mmcm_rst`=1, `busy`=1, `done`=0, `error`=0, `locked_out`=0.
  - `drp_den`=0, `drp_dwe`=0, `drp_daddr`=0, `drp_di`=0.
  - State = PWRUP_RST; entry index = 0.
- Power-up sequence: PWRUP_RST holds `mmcm_rst` for `RST_HOLD_CYCLES`, then goes to RELEASE, then LOCK_WAIT. No DRP access occurs; the bitstream defaults apply.
- IDLE:
  - `start`=1 latches `profile_sel`, clears `error`, and goes to RST_HOLD.
  - `start` is ignored in every other state.
- RST_HOLD: `mmcm_rst`=1 for `RST_HOLD_CYCLES`; entry index = 0; then RD_REQ. `mmcm_rst` stays 1 until RELEASE.
- RD_REQ: one cycle with `drp_den`=1, `drp_dwe`=0, `drp_daddr`=entry.addr. Then RD_WAIT.
- RD_WAIT:
  - On `drp_drdy`, capture `(drp_do & entry.mask) | entry.data` into the write register, then WR_REQ.
  - Timeout goes to ERR.
- WR_REQ: one cycle with `drp_den`=1, `drp_dwe`=1, `drp_daddr`=entry.addr, `drp_di`=write register. Then WR_WAIT.
- WR_WAIT:
  - On `drp_drdy`: if index = `N_ENTRIES`-1, go to RELEASE; otherwise increment index and go to RD_REQ.
  - Timeout goes to ERR.
- RELEASE: one cycle; `mmcm_rst`←0. Then LOCK_WAIT.
- LOCK_WAIT:
  - When the synchronized lock is 1, pulse `done` and go to IDLE.
  - After `LOCK_TIMEOUT` cycles, go to ERR.
- ERR: one cycle; `error`←1, `mmcm_rst`←1, `busy` stays 1; then IDLE. The MMCM is left in reset until the next `start`.
- `drp_drdy` outside RD_WAIT/WR_WAIT is ignored.
- Mask semantics: mask bit = 1 keeps the read bit; mask bit = 0 takes the bit from `data`. `data` has zeros wherever the mask is 1.

## Timing
- `drp_den` and `drp_dwe` are never high for more than one consecutive cycle. There is never more than one DRP access outstanding.
- Timeout counters start at 0 on entry to the wait state. The timeout fires when the counter reaches the limit, with `drdy` still low in that cycle. A `drdy` arriving in the same cycle as the timeout wins.
- Lock synchronizer latency is 2 cycles. An accepted `start` drops `locked_out` on the next cycle.
- Per-entry latency is 2 cycles plus the two `drdy` latencies.
- Minimum reconfiguration time is `RST_HOLD_CYCLES` + N×(2 + 2×drdy latency) + 1 + 2 + lock time.
- Asserting `rst_n` mid-sequence aborts immediately: outputs take their reset values and the power-up sequence restarts.
- Loss of lock while in IDLE only drops `locked_out`. The block takes no automatic action.

## Structure
- Package `mmcm_drp_pkg` contains:
  - `drp_entry_t` = {addr[6:0], mask[15:0], data[15:0]}.
  - `N_ENTRIES`=4.
  - `PROFILES[2][N_ENTRIES]`:
    - Profile 0 is 300 MHz: CLKOUT0 divide 2 (ClkReg1/2 at 0x08/0x09) and CLKFBOUT mult 2 (0x14/0x15).
    - Profile 1 is 150 MHz: CLKOUT0 divide 4, same CLKFBOUT.
  - The state enum.
- Sub-module `sync2`: a two-flop synchronizer for `mmcm_locked`, reset to 0.

## Test plan
- Reset release, DRP model locks 100 cycles after `mmcm_rst` falls:
  - `mmcm_rst` is 1 for 64 cycles.
  - No `drp_den` at any time.
  - `locked_out`=1 and `busy`=0 about 103 cycles after release.
  - No `done` pulse.
- `start` with `profile_sel`=1, DRP model preloaded with 0xFFFF at address 0x08 and `drdy` latency 3:
  - Exactly 4 reads and 4 writes occur, in addresses order 0x08, 0x09, 0x14, 0x15.
  - The write to 0x08 equals `(0xFFFF & mask) | data` from profile 1.
  - A single `done` pulse follows.
- DRP model never returns `drdy` on the second read:
  - ERR is reached after 255 cycles.
  - `error`=1 and `mmcm_rst`=1.
  - A following `start` clears `error`.
- Lock withheld: after `LOCK_TIMEOUT` the block sets `error` and reasserts `mmcm_rst`; no `done` pulse occurs.
- `start` pulsed again during WR_WAIT is ignored: the entry count stays 4 and there is one `done` pulse.
- `rst_n` pulsed low during RD_WAIT:
  - `drp_den` and `busy` take their reset values immediately.
  - The power-up sequence reruns with no DRP accesses.
